// File: rtl/vmc_pkg.sv
// Shared types, coin values and the price lookup used by the multi-product vending controller.
package vmc_pkg;

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} vmc_state_e;

  localparam int NICKEL  = 1;
  localparam int DIME    = 2;
  localparam int QUARTER = 5;

  // Upper bounds for the lookup; callers zero-extend their narrower sel/price tables.
  localparam int MAX_PROD = 16;
  localparam int MAX_CW   = 8;

  function automatic logic [MAX_CW-1:0] price_of(input logic [MAX_PROD-1:0]        sel,
                                                 input logic [MAX_PROD*MAX_CW-1:0] prices,
                                                 input int                         cw);
    price_of = '0;
    if ($onehot(sel)) begin
      for (int i = 0; i < MAX_PROD; i++) begin
        if (sel[i]) begin
          for (int b = 0; b < MAX_CW; b++) begin
            if (b < cw) price_of[b] = prices[i*cw + b];
          end
        end
      end
    end
  endfunction

endpackage

// File: rtl/vmc_rise_detect.sv
// Registered rising-edge detector for one synchronous coin input.
module vmc_rise_detect (
  input  logic clk,
  input  logic clr_n,
  input  logic in_i,
  output logic rise_o
);

  logic in_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) in_q <= 1'b0;
    else        in_q <= in_i;
  end

  assign rise_o = in_i & ~in_q;

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: nickel-unit credit, cancel refund, timed vend, coin-by-coin change.
// Define VMC_TIMEOUT_EN to refund idle credit after TIMEOUT_CYCLES cycles in CREDIT.
module vend_ctrl_multi
  import vmc_pkg::*;
#(
  parameter int                           NUM_PROD       = 4,
  parameter int                           CREDIT_W       = 4,
  parameter int                           MAX_CREDIT     = 7,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_LIST     = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int                           VEND_CYCLES    = 4,
  parameter int                           TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                coin_nickel,
  input  logic                coin_dime,
  input  logic                coin_quarter,
  input  logic [NUM_PROD-1:0] sel,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] price_disp,
  output logic [NUM_PROD-1:0] vend,
  output logic                change_nickel,
  output logic                change_dime,
  output logic                coin_reject,
  output logic                busy
);

  localparam int VCW = $clog2(VEND_CYCLES) + 1;

  vmc_state_e          state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [NUM_PROD-1:0] vend_q;
  logic [VCW-1:0]      vcnt_q;
  logic                change_nickel_q, change_dime_q, coin_reject_q;

  // Bit 0 = nickel, 1 = dime, 2 = quarter
  logic [2:0] coin_in, coin_rise;
  assign coin_in = {coin_quarter, coin_dime, coin_nickel};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rise
      vmc_rise_detect u_rise (
        .clk    (clk),
        .clr_n  (clr_n),
        .in_i   (coin_in[gi]),
        .rise_o (coin_rise[gi])
      );
    end
  endgenerate

  logic [CREDIT_W-1:0]           coin_val;
  logic [CREDIT_W:0]             coin_sum;
  logic                          coin_any, coin_multi, coin_fits, coin_accept;
  logic [MAX_PROD-1:0]           sel_ext;
  logic [MAX_PROD*MAX_CW-1:0]    prices_ext;
  logic [MAX_CW-1:0]             price_full;
  logic [MAX_CW-1:0]             credit_ext;
  logic                          sel_ok, timeout_hit;

  always_comb begin
    coin_val = '0;
    if (coin_rise[2])      coin_val = CREDIT_W'(QUARTER);
    else if (coin_rise[1]) coin_val = CREDIT_W'(DIME);
    else if (coin_rise[0]) coin_val = CREDIT_W'(NICKEL);
    coin_any    = |coin_rise;
    coin_multi  = $countones(coin_rise) > 1;
    coin_sum    = {1'b0, credit_q} + {1'b0, coin_val};
    coin_fits   = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    coin_accept = coin_any && coin_fits;

    sel_ext                               = '0;
    sel_ext[NUM_PROD-1:0]                 = sel;
    prices_ext                            = '0;
    prices_ext[NUM_PROD*CREDIT_W-1:0]     = PRICE_LIST;
    price_full                            = price_of(sel_ext, prices_ext, CREDIT_W);
    credit_ext                            = '0;
    credit_ext[CREDIT_W-1:0]              = credit_q;
    sel_ok = $onehot(sel) && (credit_ext >= price_full);
  end

  assign price_disp = price_full[CREDIT_W-1:0];

`ifdef VMC_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TCW-1:0] tcnt_q;

  // Only accepted coins restart the idle window; rejected coins and ignored selections do not.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                                 tcnt_q <= '0;
    else if (state_q != CREDIT || coin_accept)  tcnt_q <= '0;
    else if (!timeout_hit)                      tcnt_q <= tcnt_q + TCW'(1);
  end

  assign timeout_hit = (state_q == CREDIT) && (tcnt_q == TCW'(TIMEOUT_CYCLES - 1));
`else
  // No idle timeout in this build; TIMEOUT_CYCLES is kept so both builds share one interface.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      vend_q          <= '0;
      vcnt_q          <= '0;
      change_nickel_q <= 1'b0;
      change_dime_q   <= 1'b0;
      coin_reject_q   <= 1'b0;
    end else begin
      change_nickel_q <= 1'b0;
      change_dime_q   <= 1'b0;
      coin_reject_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (coin_any) begin
            coin_reject_q <= coin_multi || !coin_fits;
            if (coin_fits) begin
              credit_q <= coin_sum[CREDIT_W-1:0];
              state_q  <= CREDIT;
            end
          end
        end
        CREDIT: begin
          if (coin_any) begin
            coin_reject_q <= coin_multi || !coin_fits;
            if (coin_fits) credit_q <= coin_sum[CREDIT_W-1:0];
          end
          if (timeout_hit && !coin_accept) begin
            state_q <= CHANGE;
          end else if (!coin_any) begin
            if (cancel) begin
              state_q <= CHANGE;
            end else if (sel_ok) begin
              credit_q <= credit_q - price_disp;
              vend_q   <= sel;
              vcnt_q   <= '0;
              state_q  <= VEND;
            end
          end
        end
        VEND: begin
          coin_reject_q <= coin_any;
          if (vcnt_q == VCW'(VEND_CYCLES - 1)) begin
            vend_q  <= '0;
            state_q <= (credit_q != '0) ? CHANGE : IDLE;
          end else begin
            vcnt_q <= vcnt_q + VCW'(1);
          end
        end
        CHANGE: begin
          coin_reject_q <= coin_any;
          // Dimes first, a single nickel for an odd remainder, then one empty cycle back to IDLE.
          if (credit_q >= CREDIT_W'(2)) begin
            change_dime_q <= 1'b1;
            credit_q      <= credit_q - CREDIT_W'(2);
          end else if (credit_q == CREDIT_W'(1)) begin
            change_nickel_q <= 1'b1;
            credit_q        <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign credit        = credit_q;
  assign vend          = vend_q;
  assign change_nickel = change_nickel_q;
  assign change_dime   = change_dime_q;
  assign coin_reject   = coin_reject_q;
  assign busy          = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Randomized and scenario-driven bench for vend_ctrl_multi against a transaction-level reference model.
module tb_vend_ctrl_multi;

  localparam int NUM_PROD    = 4;
  localparam int MAX_CREDIT  = 7;
  localparam int VEND_CYCLES = 4;

  logic                clk = 1'b0;
  logic                clr_n;
  logic                coin_nickel, coin_dime, coin_quarter, cancel;
  logic [NUM_PROD-1:0] sel;
  logic [3:0]          credit, price_disp;
  logic [NUM_PROD-1:0] vend;
  logic                change_nickel, change_dime, coin_reject, busy;

  always #5 clk = ~clk;

  vend_ctrl_multi dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .coin_nickel   (coin_nickel),
    .coin_dime     (coin_dime),
    .coin_quarter  (coin_quarter),
    .sel           (sel),
    .cancel        (cancel),
    .credit        (credit),
    .price_disp    (price_disp),
    .vend          (vend),
    .change_nickel (change_nickel),
    .change_dime   (change_dime),
    .coin_reject   (coin_reject),
    .busy          (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is planned as a list of post-edge snapshots.
  typedef struct {
    int         credit;
    logic [3:0] vend;
    bit         nick;
    bit         dime;
  } snap_t;

  snap_t sched[$];
  int    m_credit = 0;
  bit    m_busy = 0;
  bit    pn = 0, pd = 0, pq = 0;
  logic [3:0] e_vend = '0;
  bit    e_nick = 0, e_dime = 0, e_rej = 0;

  function automatic int price_m(input logic [3:0] s);
    int pr [4] = '{3, 4, 5, 6};
    price_m = 0;
    if ($countones(s) == 1)
      for (int i = 0; i < 4; i++) if (s[i]) price_m = pr[i];
  endfunction

  task automatic plan_change(input int amount);
    int r = amount;
    sched.push_back('{r, 4'b0, 1'b0, 1'b0});
    while (r >= 2) begin
      r -= 2;
      sched.push_back('{r, 4'b0, 1'b0, 1'b1});
    end
    if (r == 1) sched.push_back('{0, 4'b0, 1'b1, 1'b0});
  endtask

  task automatic model_step(input logic n, input logic d, input logic q, input logic [3:0] s, input logic c);
    bit rn, rd, rq;
    int nr, val, p, rem;
    snap_t sn;
    rn = n && !pn;
    rd = d && !pd;
    rq = q && !pq;
    nr = int'(rn) + int'(rd) + int'(rq);
    e_nick = 0; e_dime = 0; e_rej = 0;
    if (m_busy) begin
      e_rej = (nr > 0);
    end else if (nr > 0) begin
      val = rq ? 5 : (rd ? 2 : 1);
      if (m_credit + val <= MAX_CREDIT) begin
        m_credit += val;
        e_rej = (nr > 1);
      end else begin
        e_rej = 1;
      end
    end else if (m_credit > 0) begin
      p = price_m(s);
      if (c) begin
        plan_change(m_credit);
      end else if (p > 0 && m_credit >= p) begin
        rem = m_credit - p;
        repeat (VEND_CYCLES) sched.push_back('{rem, s, 1'b0, 1'b0});
        if (rem > 0) plan_change(rem);
      end
    end
    if (sched.size() > 0) begin
      sn = sched.pop_front();
      m_credit = sn.credit;
      e_vend = sn.vend;
      e_nick = sn.nick;
      e_dime = sn.dime;
      m_busy = 1;
    end else begin
      e_vend = '0;
      m_busy = 0;
    end
    pn = n; pd = d; pq = q;
  endtask

  task automatic model_reset();
    sched.delete();
    m_credit = 0; m_busy = 0;
    pn = 0; pd = 0; pq = 0;
    e_vend = '0; e_nick = 0; e_dime = 0; e_rej = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check_eq({ctx, ".credit"}, credit, m_credit);
    check_eq({ctx, ".vend"}, vend, e_vend);
    check_eq({ctx, ".change_nickel"}, change_nickel, e_nick);
    check_eq({ctx, ".change_dime"}, change_dime, e_dime);
    check_eq({ctx, ".coin_reject"}, coin_reject, e_rej);
    check_eq({ctx, ".busy"}, busy, m_busy);
  endtask

  task automatic apply(input logic n, input logic d, input logic q, input logic [3:0] s, input logic c);
    @(negedge clk);
    check_outputs("cyc");
    coin_nickel = n; coin_dime = d; coin_quarter = q; sel = s; cancel = c;
    #1;
    check_eq("price_disp", price_disp, price_m(s));
    model_step(n, d, q, s, c);
  endtask

  task automatic idle(input int cycles, input logic [3:0] s);
    repeat (cycles) apply(0, 0, 0, s, 0);
  endtask

  task automatic check_reset_zero(input string ctx);
    check_eq({ctx, ".credit"}, credit, 0);
    check_eq({ctx, ".vend"}, vend, 0);
    check_eq({ctx, ".change_nickel"}, change_nickel, 0);
    check_eq({ctx, ".change_dime"}, change_dime, 0);
    check_eq({ctx, ".coin_reject"}, coin_reject, 0);
    check_eq({ctx, ".busy"}, busy, 0);
  endtask

  initial begin
    logic [3:0] rs;
    clr_n = 1'b0;
    coin_nickel = 0; coin_dime = 0; coin_quarter = 0; sel = '0; cancel = 0;
    #12;
    check_reset_zero("reset");
    @(negedge clk);
    clr_n = 1'b1;

    // Quarter + nickel, buy product 0: 4 vend cycles, then one dime and one nickel back
    apply(0, 0, 1, 4'b0000, 0); apply(0, 0, 0, 4'b0000, 0);
    apply(1, 0, 0, 4'b0000, 0); apply(0, 0, 0, 4'b0000, 0);
    idle(10, 4'b0001);
    idle(2, 4'b0000);
    $display("scenario buy_p0_with_change done, credit=%0d", credit);

    // Three dimes, overflowing quarter, buy product 3 exactly
    repeat (3) begin apply(0, 1, 0, 4'b0000, 0); apply(0, 0, 0, 4'b0000, 0); end
    apply(0, 0, 1, 4'b0000, 0); apply(0, 0, 0, 4'b0000, 0);
    idle(7, 4'b1000);
    idle(2, 4'b0000);
    $display("scenario overflow_then_exact_vend done, credit=%0d", credit);

    // Insufficient credit, then cancel
    apply(0, 1, 0, 4'b0000, 0); apply(0, 0, 0, 4'b0000, 0);
    idle(3, 4'b0001);
    apply(0, 0, 0, 4'b0000, 1);
    idle(4, 4'b0000);
    $display("scenario insufficient_then_cancel done, credit=%0d", credit);

    // Quarter and dime together from IDLE; then refund
    apply(0, 1, 1, 4'b0000, 0); apply(0, 0, 0, 4'b0000, 0);
    apply(0, 0, 0, 4'b0000, 1);
    idle(6, 4'b0000);
    $display("scenario simultaneous_coins done, credit=%0d", credit);

    // Nickel during VEND, then asynchronous reset in the middle of CHANGE
    apply(0, 0, 1, 4'b0000, 0); apply(0, 0, 0, 4'b0000, 0);
    apply(1, 0, 0, 4'b0000, 0); apply(0, 0, 0, 4'b0000, 0);
    apply(0, 0, 0, 4'b0001, 0);
    apply(1, 0, 0, 4'b0000, 0); apply(0, 0, 0, 4'b0000, 0);
    idle(3, 4'b0000);
    check_eq("midchange.busy", busy, 1);
    #2;
    clr_n = 1'b0;
    #1;
    check_reset_zero("async_reset");
    model_reset();
    #2;
    clr_n = 1'b1;
    $display("scenario reset_mid_change done, credit=%0d", credit);

    // Credit persists without the idle timeout
    apply(1, 0, 0, 4'b0000, 0);
    idle(50, 4'b0000);
    check_eq("hold50.credit", credit, 1);
    apply(0, 0, 0, 4'b0000, 1);
    idle(4, 4'b0000);
    $display("scenario credit_hold_50 done, credit=%0d", credit);

    // Randomized traffic
    rs = '0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       rs = 4'b0000;
          3:       rs = 4'($urandom);
          default: rs = 4'b0001 << $urandom_range(0, 3);
        endcase
      end
      apply($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            rs, $urandom_range(0, 24) == 0);
    end
    idle(20, 4'b0000);
    $display("scenario random_traffic done, credit=%0d", credit);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised successor to the single-price-table vending FSM.
- Adds:
  - a configurable product count and price table;
  - credit held in 5-cent units with overflow rejection;
  - a cancel/refund path;
  - timed vend pulses;
  - sequential coin-by-coin change payout.
- Sits between the debounced front-panel inputs (coins, select switches, cancel) and the display/LED drivers.

Parameters:
- NUM_PROD, 4: number of products; width of sel and vend.
- CREDIT_W, 4: credit/price width, in nickels (5-cent units).
- MAX_CREDIT, 7: highest credit accepted (7 = 35c).
- PRICE_LIST, {4'd6,4'd5,4'd4,4'd3}: packed NUM_PROD*CREDIT_W prices. Product i occupies slice [i*CREDIT_W +: CREDIT_W]. Default prices: p0=15c, p1=20c, p2=25c, p3=30c.
- VEND_CYCLES, 4: cycles vend[i] is held high.
- TIMEOUT_CYCLES, 1000: idle-refund delay. Used only with VMC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- clr_n  in  1  asynchronous active-low reset.
- coin_nickel  in  1  synchronous level input; rising edge = 5c inserted.
- coin_dime  in  1  synchronous level input; rising edge = 10c inserted.
- coin_quarter  in  1  synchronous level input; rising edge = 25c inserted.
- sel  in  NUM_PROD  product select, level-sensitive, must be one-hot.
- cancel  in  1  level; request refund.
- credit  out  CREDIT_W  current credit in nickels.
- price_disp  out  CREDIT_W  price of the selected product; 0 if sel is not one-hot.
- vend  out  NUM_PROD  one-hot dispense strobe.
- change_nickel  out  1  one-cycle pulse per 5c returned.
- change_dime  out  1  one-cycle pulse per 10c returned.
- coin_reject  out  1  one-cycle pulse when a coin edge is refused.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset state (clr_n low, asynchronous): all outputs 0, state IDLE, credit 0, edge-detect registers 0, vend counter 0.
- Coin detection:
  - Each coin input has one register; rise = in & ~in_q.
  - Credit updates at the same clock edge that first samples the input high, so the new value is visible one cycle after the input rises.
- Coin priority: multiple rises in one cycle → only the highest value is considered (quarter > dime > nickel). The others are dropped and coin_reject pulses.
- Overflow: if credit + coin value > MAX_CREDIT, the coin is rejected (coin_reject pulse) and credit is unchanged. Credit never saturates or wraps.
- States:
  - IDLE: credit == 0. An accepted coin → CREDIT.
  - CREDIT: coins are accepted. Priority within a cycle is coin > cancel > sel.
    - cancel → CHANGE, with the remainder equal to credit.
    - sel one-hot with credit >= price[i] → VEND: credit <= credit - price[i], vend[i] is latched.
    - sel one-hot with credit < price[i] → ignored; stay in CREDIT.
    - sel not one-hot → ignored.
  - VEND:
    - vend[i] is high for exactly VEND_CYCLES cycles.
    - Afterwards → CHANGE if credit > 0, else IDLE.
  - CHANGE: one coin per cycle.
    - credit >= 2: change_dime pulses and credit -= 2.
    - credit == 1: change_nickel pulses and credit -= 1.
    - credit == 0 → IDLE; no pulse in that cycle.
- While busy: coin rises are rejected (coin_reject pulses); sel and cancel are ignored.
- sel held through VEND/CHANGE does not re-trigger until the FSM returns to CREDIT. A fresh coin is required, since IDLE ignores sel.
- price_disp is combinational from sel in every state.
- Reset mid-vend or mid-change: the transaction is aborted and credit is lost. This is the documented behaviour.

Optional Feature:
- VMC_TIMEOUT_EN defined:
  - A counter runs in CREDIT and clears on any accepted coin.
  - On reaching TIMEOUT_CYCLES-1 → CHANGE (full refund).
  - Rejected coins and ignored selections do not clear the counter.
- VMC_TIMEOUT_EN undefined: no counter is present, and CREDIT persists indefinitely.

Decomposition:
- Package vmc_pkg:
  - state enum (IDLE, CREDIT, VEND, CHANGE);
  - coin value constants NICKEL=1, DIME=2, QUARTER=5;
  - function price_of(sel), which returns 0 for a non-one-hot sel.
- Sub-module vmc_rise_detect: registered rise detector, instantiated three times.

Test Plan:
- Quarter, then nickel (30c), sel=4'b0001 → vend[0] high 4 cycles; then change_dime ×1, change_nickel ×1; credit 6→3→1→0; then IDLE.
- Dime ×3 (30c), then quarter → coin_reject pulse, credit stays 6. sel=4'b1000 → vend[3], no change pulses, IDLE.
- Dime (10c), sel=4'b0001 → no vend, credit stays 2. cancel → one change_dime pulse, credit 0, IDLE.
- Quarter and dime rising in the same cycle from IDLE → credit=5, one coin_reject pulse.
- Nickel inserted during VEND → coin_reject pulse, credit unaffected. clr_n low mid-CHANGE → all outputs 0 asynchronously, IDLE.
- With VMC_TIMEOUT_EN and TIMEOUT_CYCLES=10: nickel, then 10 idle cycles → change_nickel pulse, IDLE. Without the macro: credit=1 is held for 50 cycles.
